alu32_core: RTL and testbench
=============================

// Module: alu32_core
// PURPOSE
//   32-bit integer ALU with registered result. Selects one of eight operations on operands A and B
//   via a 3-bit opcode. Result and status flags are captured on the rising clock edge (1-cycle latency).
//   Sits in the execute stage of the lab datapath, between the register-file read ports and write-back.
// PARAMETERS
//   WIDTH  32  operand/result width in bits (>= 8; shift amount uses B[$clog2(WIDTH)-1:0])
// PORTS
//   clk       in   1      rising-edge clock
//   rst_n     in   1      asynchronous reset, active low
//   A         in   WIDTH  operand A (unsigned/two's complement per op)
//   B         in   WIDTH  operand B
//   ctrl      in   3      operation select
//   Q         out  WIDTH  registered result
//   zero      out  1      registered: 1 when result == 0
//   carry     out  1      registered: carry-out (ADD) / NOT borrow (SUB); 0 for other ops
//   overflow  out  1      registered: signed overflow (ADD/SUB only); 0 for other ops
// BEHAVIOUR
//   - Reset: rst_n low asynchronously forces Q=0, zero=1, carry=0, overflow=0; held while rst_n low.
//   - After reset release, every rising clk edge registers op(A,B,ctrl); no enable, no stall.
//   - Latency: inputs sampled at edge N appear on Q/flags after edge N; outputs stable between edges.
//   - Opcode map (ctrl):
//       000 ADD  Q = A + B (mod 2^WIDTH); carry = bit WIDTH of the (WIDTH+1)-bit sum
//       001 SUB  Q = A - B (mod 2^WIDTH), i.e. A + ~B + 1; carry = 1 when A >= B unsigned
//       010 AND  Q = A & B
//       011 OR   Q = A | B
//       100 XOR  Q = A ^ B
//       101 SLT  Q = {WIDTH-1 zeros, (signed A < signed B)}
//       110 SLL  Q = A << B[4:0] (zero fill)
//       111 SRL  Q = A >> B[4:0] (logical, zero fill)
//   - Overflow: ADD = (A[msb]==B[msb]) && (Q[msb]!=A[msb]);
//     SUB = (A[msb]!=B[msb]) && (Q[msb]!=A[msb]).
//   - zero computed from the next Q value, registered with it (no extra cycle).
//   - Shift amount 0 passes A unchanged; shift bits above [4:0] are ignored.
//   - Opcode change takes effect on the next edge only; no internal state beyond output registers.
//   - Reset asserted mid-stream: outputs clear immediately, regardless of clk; first edge after
//     release captures the current inputs.
// TESTING
//   1. rst_n=0, random A/B/ctrl, toggle clk -> Q=0, zero=1, carry=0, overflow=0 throughout.
//   2. A=8, B=5, ctrl=000/001/010/011 on successive edges -> Q=13, 3, 0, 13;
//      zero=1 only for AND; carry=1 for SUB.
//   3. ADD A=0x7FFFFFFF, B=1 -> Q=0x80000000, overflow=1, carry=0;
//      ADD A=0xFFFFFFFF, B=1 -> Q=0, zero=1, carry=1.
//   4. SUB A=5, B=8 -> Q=0xFFFFFFFD, carry=0;
//      SLT A=0xFFFFFFFF(-1), B=1 -> Q=1; SLT A=1, B=0xFFFFFFFF -> Q=0.
//   5. XOR A=0xF0F0F0F0, B=0xFFFF0000 -> Q=0x0F0FF0F0;
//      SLL A=1, B=31 -> Q=0x80000000; SRL A=0x80000000, B=0x21 -> Q=0x40000000.
//   6. Assert rst_n low between edges while Q=13 -> Q=0 before next edge;
//      release, next edge -> Q matches current op.

Source files
------------

// File: rtl/alu32_core.sv
// Execute-stage integer ALU: eight operations selected by ctrl, with the result
// and status flags captured on the rising clock edge (one cycle of latency).
module alu32_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       ctrl,
    output logic [WIDTH-1:0] Q,
    output logic             zero,
    output logic             carry,
    output logic             overflow
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;
    localparam logic [2:0] OP_SRL = 3'b111;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [SHW-1:0]   w_shamt;
    logic             w_slt;
    logic [WIDTH-1:0] w_res;
    logic             w_carry;
    logic             w_ovf;

    logic [WIDTH-1:0] r_q;
    logic             r_zero;
    logic             r_carry;
    logic             r_ovf;

    // Subtraction as A + ~B + 1 so the top bit is directly the "no borrow" flag.
    assign w_sum   = {1'b0, A} + {1'b0, B};
    assign w_diff  = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
    assign w_shamt = B[SHW-1:0];
    assign w_slt   = $signed(A) < $signed(B);

    always_comb begin
        w_res   = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        case (ctrl)
            OP_ADD: begin
                w_res   = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
                w_ovf   = (A[WIDTH-1] == B[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                w_res   = w_diff[WIDTH-1:0];
                w_carry = w_diff[WIDTH];
                w_ovf   = (A[WIDTH-1] != B[WIDTH-1]) && (w_diff[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND: w_res = A & B;
            OP_OR:  w_res = A | B;
            OP_XOR: w_res = A ^ B;
            OP_SLT: w_res = {{(WIDTH-1){1'b0}}, w_slt};
            OP_SLL: w_res = A << w_shamt;
            OP_SRL: w_res = A >> w_shamt;
            default: w_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q     <= '0;
            r_zero  <= 1'b1;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_q     <= w_res;
            r_zero  <= (w_res == '0);
            r_carry <= w_carry;
            r_ovf   <= w_ovf;
        end
    end

    assign Q        = r_q;
    assign zero     = r_zero;
    assign carry    = r_carry;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_alu32_core.sv
// Bench for alu32_core: directed literal cases plus randomized traffic, all
// checked every cycle against an arithmetic reference model of the ALU.
module tb_alu32_core;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic [2:0]  ctrl = '0;
    logic [31:0] Q;
    logic        zero;
    logic        carry;
    logic        overflow;

    int total = 0;
    int bad = 0;
    logic checkOn = 1'b0;

    logic [31:0] expQ = '0;
    logic        expZ = 1'b1;
    logic        expC = 1'b0;
    logic        expV = 1'b0;
    logic [31:0] mQ;
    logic        mZ;
    logic        mC;
    logic        mV;

    alu32_core #(.WIDTH(32)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .A(A),
        .B(B),
        .ctrl(ctrl),
        .Q(Q),
        .zero(zero),
        .carry(carry),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Reference model: wide integer arithmetic, range checks for signed overflow.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                                  output logic [31:0] q, output logic z, output logic c, output logic v);
        longint unsigned ua = {32'h0, a};
        longint unsigned ub = {32'h0, b};
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint unsigned ur;
        longint sr;
        int sh = int'(b % 32);
        q = '0;
        c = 1'b0;
        v = 1'b0;
        case (op)
            3'd0: begin
                ur = ua + ub;
                q  = ur[31:0];
                c  = (ur >= 64'h1_0000_0000);
                sr = sa + sb;
                v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            3'd1: begin
                ur = ua - ub;
                q  = ur[31:0];
                c  = (ua >= ub);
                sr = sa - sb;
                v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            3'd2: q = a & b;
            3'd3: q = a | b;
            3'd4: q = a ^ b;
            3'd5: q = (sa < sb) ? 32'd1 : 32'd0;
            3'd6: begin
                ur = ua << sh;
                q  = ur[31:0];
            end
            default: begin
                ur = ua >> sh;
                q  = ur[31:0];
            end
        endcase
        z = (q == 32'h0);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            expQ <= '0;
            expZ <= 1'b1;
            expC <= 1'b0;
            expV <= 1'b0;
        end else begin
            model(A, B, ctrl, mQ, mZ, mC, mV);
            expQ <= mQ;
            expZ <= mZ;
            expC <= mC;
            expV <= mV;
        end
    end

    always @(negedge clk) begin
        if (checkOn) begin
            total++;
            if (Q !== expQ || zero !== expZ || carry !== expC || overflow !== expV) begin
                bad++;
                $display("[TB] FAIL cycleCheck t=%0t got Q=%h z=%b c=%b v=%b want Q=%h z=%b c=%b v=%b",
                         $time, Q, zero, carry, overflow, expQ, expZ, expC, expV);
            end
        end
    end

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        @(negedge clk);
        #1;
        A = a;
        B = b;
        ctrl = op;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] q, input logic z,
                               input logic c, input logic v);
        total++;
        if (Q !== q || zero !== z || carry !== c || overflow !== v) begin
            bad++;
            $display("[TB] FAIL %s got Q=%h z=%b c=%b v=%b want Q=%h z=%b c=%b v=%b",
                     name, Q, zero, carry, overflow, q, z, c, v);
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        $display("[TB] starting alu32_core bench");
        @(posedge clk);
        checkOn = 1'b1;

        repeat (4) begin
            @(negedge clk);
            #1;
            A = $urandom;
            B = $urandom;
            ctrl = 3'($urandom);
            @(posedge clk);
            #1;
            checkOutput("resetHeld", 32'h0, 1'b1, 1'b0, 1'b0);
        end
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        applyStimulus(32'd8, 32'd5, 3'b000);
        checkOutput("add8_5", 32'd13, 1'b0, 1'b0, 1'b0);
        applyStimulus(32'd8, 32'd5, 3'b001);
        checkOutput("sub8_5", 32'd3, 1'b0, 1'b1, 1'b0);
        applyStimulus(32'd8, 32'd5, 3'b010);
        checkOutput("and8_5", 32'd0, 1'b1, 1'b0, 1'b0);
        applyStimulus(32'd8, 32'd5, 3'b011);
        checkOutput("or8_5", 32'd13, 1'b0, 1'b0, 1'b0);

        applyStimulus(32'h7FFF_FFFF, 32'd1, 3'b000);
        checkOutput("addOvf", 32'h8000_0000, 1'b0, 1'b0, 1'b1);
        applyStimulus(32'hFFFF_FFFF, 32'd1, 3'b000);
        checkOutput("addCarry", 32'h0, 1'b1, 1'b1, 1'b0);
        applyStimulus(32'd5, 32'd8, 3'b001);
        checkOutput("subBorrow", 32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0);
        applyStimulus(32'd8, 32'd8, 3'b001);
        checkOutput("subEqual", 32'h0, 1'b1, 1'b1, 1'b0);
        applyStimulus(32'h8000_0000, 32'd1, 3'b001);
        checkOutput("subOvf", 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1);
        applyStimulus(32'hFFFF_FFFF, 32'd1, 3'b101);
        checkOutput("sltNeg", 32'd1, 1'b0, 1'b0, 1'b0);
        applyStimulus(32'd1, 32'hFFFF_FFFF, 3'b101);
        checkOutput("sltPos", 32'd0, 1'b1, 1'b0, 1'b0);
        applyStimulus(32'hF0F0_F0F0, 32'hFFFF_0000, 3'b100);
        checkOutput("xor", 32'h0F0F_F0F0, 1'b0, 1'b0, 1'b0);
        applyStimulus(32'd1, 32'd31, 3'b110);
        checkOutput("sll31", 32'h8000_0000, 1'b0, 1'b0, 1'b0);
        applyStimulus(32'h8000_0000, 32'h21, 3'b111);
        checkOutput("srlMasked", 32'h4000_0000, 1'b0, 1'b0, 1'b0);
        applyStimulus(32'h0000_1234, 32'h20, 3'b110);
        checkOutput("sllZero", 32'h0000_1234, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset between edges, held across one edge, then released.
        applyStimulus(32'd8, 32'd5, 3'b000);
        checkOutput("preReset", 32'd13, 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("asyncReset", 32'h0, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("resetAcrossEdge", 32'h0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("afterRelease", 32'd13, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            #1;
            A = pick();
            B = pick();
            ctrl = 3'($urandom);
            rst_n = ($urandom_range(0, 199) != 0);
        end
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
